ddr_emif_arbiter: RTL and testbench

Two-port arbiter for the single DDR3 EMIF Avalon-MM port on `ddr_emif_clk`. Requester 0 is the pattern fetch path: read-only, display-latency critical, high priority. Requester 1 is the pattern loader: read/write, host side, uses bounded-starvation fairness. The arbiter multiplexes commands, keeps write bursts atomic, and routes in-order read data back to the issuing requester through an owner-tag FIFO.

---
 rtl/ddr_emif_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ddr_emif_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_emif_arbiter.sv
// rtl/ddr_emif_arbiter.sv - two-port DDR EMIF command arbiter with owner-tag read routing
//
// Purpose: shares one Avalon-MM EMIF port between r0 (read-only pattern fetch,
// high priority) and r1 (read/write pattern loader, bounded-starvation fairness).
// Write bursts from r1 are kept atomic. Read data is routed in order to the
// issuing requester through an owner/beat tag FIFO.
//
// Ports:
//   ddr_emif_clk, ddr_emif_rst_n    clock, asynchronous active-low reset
//   r0_*                            r0 read command, waitrequest, read data return
//   r1_*                            r1 read/write command, waitrequest, read data return
//   ddr_emif_ready/read_data/rddata_valid   EMIF status and read return
//   ddr_emif_read/write/addr/write_data/byte_enable/burst_count   EMIF command
//   err_orphan                      sticky: read data arrived with no outstanding tag
module ddr_emif_arbiter #(
  parameter  int ADDR_W     = 22,
  parameter  int DATA_W     = 256,
  parameter  int BURST_W    = 5,
  parameter  int TAG_DEPTH  = 8,
  parameter  int MAX_STREAK = 4,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic               ddr_emif_clk,
  input  logic               ddr_emif_rst_n,
  input  logic               r0_read,
  input  logic [ADDR_W-1:0]  r0_addr,
  input  logic [BURST_W-1:0] r0_burst_count,
  output logic               r0_waitrequest,
  output logic [DATA_W-1:0]  r0_rddata,
  output logic               r0_rddata_valid,
  input  logic               r1_read,
  input  logic               r1_write,
  input  logic [ADDR_W-1:0]  r1_addr,
  input  logic [BURST_W-1:0] r1_burst_count,
  input  logic [DATA_W-1:0]  r1_write_data,
  input  logic [BE_W-1:0]    r1_byte_enable,
  output logic               r1_waitrequest,
  output logic [DATA_W-1:0]  r1_rddata,
  output logic               r1_rddata_valid,
  input  logic               ddr_emif_ready,
  input  logic [DATA_W-1:0]  ddr_emif_read_data,
  input  logic               ddr_emif_rddata_valid,
  output logic               ddr_emif_read,
  output logic               ddr_emif_write,
  output logic [ADDR_W-1:0]  ddr_emif_addr,
  output logic [DATA_W-1:0]  ddr_emif_write_data,
  output logic [BE_W-1:0]    ddr_emif_byte_enable,
  output logic [BURST_W-1:0] ddr_emif_burst_count,
  output logic               err_orphan
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_R0, ARB_R1, ARB_WR_BURST} arb_state_t;

  arb_state_t         r_state, w_state_nxt, w_arb;
  logic [SW-1:0]      r_streak, w_streak_inc, w_streak_arb;
  logic [BURST_W-1:0] r_beats, r_wr_bc;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_tag_cnt;
  logic               r_tag_owner [TAG_DEPTH];
  logic [BURST_W-1:0] r_tag_beats [TAG_DEPTH];

  logic               w_r1_req, w_tag_full, w_tag_empty;
  logic               w_acc0, w_acc1, w_beat_acc, w_last_beat;
  logic [BURST_W-1:0] w_r0_beats, w_r1_beats, w_push_beats;
  logic               w_push, w_pop, w_head_owner, w_rd_hit;

  assign w_r1_req    = r1_read | r1_write;
  assign w_tag_full  = (r_tag_cnt == CW'(TAG_DEPTH));
  assign w_tag_empty = (r_tag_cnt == '0);

  // A zero burst count is illegal; count it as a single beat.
  assign w_r0_beats = (r0_burst_count == '0) ? BURST_W'(1) : r0_burst_count;
  assign w_r1_beats = (r1_burst_count == '0) ? BURST_W'(1) : r1_burst_count;

  assign w_acc0      = (r_state == ARB_R0) && r0_read && ddr_emif_ready && !w_tag_full;
  assign w_acc1      = (r_state == ARB_R1) && w_r1_req && ddr_emif_ready && !(r1_read && w_tag_full);
  assign w_beat_acc  = (r_state == ARB_WR_BURST) && r1_write && ddr_emif_ready;
  assign w_last_beat = w_beat_acc && (r_beats == BURST_W'(1));

  // Arbitration uses the streak value including the r0 accept happening now,
  // so r1 gets the slot right after the MAX_STREAK-th consecutive r0 accept.
  assign w_streak_inc = (w_acc0 && w_r1_req && (r_streak != SW'(MAX_STREAK)))
                        ? r_streak + SW'(1) : r_streak;
  assign w_streak_arb = w_r1_req ? w_streak_inc : '0;
  assign w_arb = (w_r1_req && ((w_streak_arb == SW'(MAX_STREAK)) || !r0_read)) ? ARB_R1 :
                 (r0_read ? ARB_R0 : ARB_IDLE);

  assign w_push       = w_acc0 || (w_acc1 && r1_read);
  assign w_push_beats = w_acc0 ? w_r0_beats : w_r1_beats;
  assign w_head_owner = r_tag_owner[r_rd_ptr];
  assign w_rd_hit     = ddr_emif_rddata_valid && !w_tag_empty;
  assign w_pop        = w_rd_hit && (r_tag_beats[r_rd_ptr] == BURST_W'(1));

  assign r0_rddata       = ddr_emif_read_data;
  assign r1_rddata       = ddr_emif_read_data;
  assign r0_rddata_valid = w_rd_hit && !w_head_owner;
  assign r1_rddata_valid = w_rd_hit &&  w_head_owner;

  always_comb begin
    w_state_nxt          = r_state;
    ddr_emif_read        = 1'b0;
    ddr_emif_write       = 1'b0;
    ddr_emif_addr        = '0;
    ddr_emif_write_data  = '0;
    ddr_emif_byte_enable = '0;
    ddr_emif_burst_count = '0;
    r0_waitrequest       = 1'b1;
    r1_waitrequest       = 1'b1;
    case (r_state)
      ARB_IDLE: w_state_nxt = w_arb;
      ARB_R0: begin
        ddr_emif_read        = r0_read;
        ddr_emif_addr        = r0_addr;
        ddr_emif_burst_count = r0_burst_count;
        r0_waitrequest       = !ddr_emif_ready || (r0_read && w_tag_full);
        if (w_acc0)        w_state_nxt = w_arb;
        else if (!r0_read) w_state_nxt = ARB_IDLE;
      end
      ARB_R1: begin
        ddr_emif_read        = r1_read;
        ddr_emif_write       = r1_write;
        ddr_emif_addr        = r1_addr;
        ddr_emif_write_data  = r1_write_data;
        ddr_emif_byte_enable = r1_byte_enable;
        ddr_emif_burst_count = r1_burst_count;
        r1_waitrequest       = !ddr_emif_ready || (r1_read && w_tag_full);
        if (w_acc1)
          w_state_nxt = (r1_write && (w_r1_beats > BURST_W'(1))) ? ARB_WR_BURST : w_arb;
        else if (!w_r1_req)
          w_state_nxt = ARB_IDLE;
      end
      ARB_WR_BURST: begin
        // Address and burst count stay at the first-beat values.
        ddr_emif_write       = r1_write;
        ddr_emif_addr        = r_wr_addr;
        ddr_emif_write_data  = r1_write_data;
        ddr_emif_byte_enable = r1_byte_enable;
        ddr_emif_burst_count = r_wr_bc;
        r1_waitrequest       = !ddr_emif_ready;
        if (w_last_beat) w_state_nxt = w_arb;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) begin
      r_state    <= ARB_IDLE;
      r_streak   <= '0;
      r_beats    <= '0;
      r_wr_addr  <= '0;
      r_wr_bc    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tag_cnt  <= '0;
      err_orphan <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= ((w_state_nxt == ARB_R1) || !w_r1_req) ? '0 : w_streak_inc;
      if (w_acc1 && r1_write) begin
        r_beats   <= w_r1_beats - BURST_W'(1);
        r_wr_addr <= r1_addr;
        r_wr_bc   <= r1_burst_count;
      end else if (w_beat_acc) begin
        r_beats <= r_beats - BURST_W'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_tag_cnt <= r_tag_cnt + CW'(w_push) - CW'(w_pop);
      if (ddr_emif_rddata_valid && w_tag_empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read when the count says valid.
  // Push never targets the head entry while it is live, since a full FIFO blocks pushes.
  always_ff @(posedge ddr_emif_clk) begin
    if (w_push) begin
      r_tag_owner[r_wr_ptr] <= (r_state == ARB_R1);
      r_tag_beats[r_wr_ptr] <= w_push_beats;
    end
    if (w_rd_hit && !w_pop) r_tag_beats[r_rd_ptr] <= r_tag_beats[r_rd_ptr] - BURST_W'(1);
  end

endmodule

// File: tb/tb_ddr_emif_arbiter.sv
// tb/tb_ddr_emif_arbiter.sv - directed self-checking bench for ddr_emif_arbiter
module tb_ddr_emif_arbiter;
  localparam int ADDR_W = 22, DATA_W = 256, BURST_W = 5, BE_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic r0_read = 0, r1_read = 0, r1_write = 0;
  logic [ADDR_W-1:0]  r0_addr = '0, r1_addr = '0;
  logic [BURST_W-1:0] r0_burst_count = '0, r1_burst_count = '0;
  logic [DATA_W-1:0]  r1_write_data = '0, ddr_emif_read_data = '0;
  logic [BE_W-1:0]    r1_byte_enable = '0;
  logic ddr_emif_ready = 1'b1, ddr_emif_rddata_valid = 1'b0;
  logic r0_waitrequest, r1_waitrequest, r0_rddata_valid, r1_rddata_valid;
  logic [DATA_W-1:0] r0_rddata, r1_rddata, ddr_emif_write_data;
  logic ddr_emif_read, ddr_emif_write, err_orphan;
  logic [ADDR_W-1:0] ddr_emif_addr;
  logic [BE_W-1:0] ddr_emif_byte_enable;
  logic [BURST_W-1:0] ddr_emif_burst_count;

  int n_checks = 0;
  int n_errors = 0;

  ddr_emif_arbiter dut (
    .ddr_emif_clk(clk), .ddr_emif_rst_n(rst_n),
    .r0_read(r0_read), .r0_addr(r0_addr), .r0_burst_count(r0_burst_count),
    .r0_waitrequest(r0_waitrequest), .r0_rddata(r0_rddata), .r0_rddata_valid(r0_rddata_valid),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_burst_count(r1_burst_count),
    .r1_write_data(r1_write_data), .r1_byte_enable(r1_byte_enable),
    .r1_waitrequest(r1_waitrequest), .r1_rddata(r1_rddata), .r1_rddata_valid(r1_rddata_valid),
    .ddr_emif_ready(ddr_emif_ready), .ddr_emif_read_data(ddr_emif_read_data),
    .ddr_emif_rddata_valid(ddr_emif_rddata_valid),
    .ddr_emif_read(ddr_emif_read), .ddr_emif_write(ddr_emif_write), .ddr_emif_addr(ddr_emif_addr),
    .ddr_emif_write_data(ddr_emif_write_data), .ddr_emif_byte_enable(ddr_emif_byte_enable),
    .ddr_emif_burst_count(ddr_emif_burst_count), .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single read from an idle arbiter: grant edge, accept edge, then back to idle.
  task automatic rd_cmd(input logic own, input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc);
    if (own) begin r1_read = 1; r1_addr = addr; r1_burst_count = bc; end
    else     begin r0_read = 1; r0_addr = addr; r0_burst_count = bc; end
    tick;
    chk("rd_cmd_wait", own ? r1_waitrequest : r0_waitrequest, 1'b0);
    chk("rd_cmd_addr", ddr_emif_addr, addr);
    tick;
    r0_read = 0; r1_read = 0;
    tick;
  endtask

  // One returned beat, expected to go to requester `own`.
  task automatic ret(input logic own, input logic [DATA_W-1:0] d);
    ddr_emif_rddata_valid = 1; ddr_emif_read_data = d;
    #1;
    chk("ret_v0", r0_rddata_valid, !own);
    chk("ret_v1", r1_rddata_valid, own);
    chk("ret_data", own ? r1_rddata : r0_rddata, d);
    tick;
    ddr_emif_rddata_valid = 0;
  endtask

  logic fair_own [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  logic route_own [6] = '{0, 0, 1, 1, 1, 0};

  initial begin
    // Reset state
    tick; tick;
    chk("rst_read", ddr_emif_read, 1'b0);
    chk("rst_write", ddr_emif_write, 1'b0);
    chk("rst_w0", r0_waitrequest, 1'b1);
    chk("rst_w1", r1_waitrequest, 1'b1);
    chk("rst_v0", r0_rddata_valid, 1'b0);
    chk("rst_v1", r1_rddata_valid, 1'b0);
    chk("rst_err", err_orphan, 1'b0);
    rst_n = 1;
    tick;

    // Lone r0 reads: one grant cycle, then 4 back-to-back reads
    r0_read = 1; r0_addr = 22'h10; r0_burst_count = 1;
    #1;
    chk("lone_idle_read", ddr_emif_read, 1'b0);
    chk("lone_idle_w0", r0_waitrequest, 1'b1);
    tick;
    for (int i = 0; i < 4; i++) begin
      r0_addr = ADDR_W'(22'h10 + i);
      #1;
      chk("lone_read", ddr_emif_read, 1'b1);
      chk("lone_addr", ddr_emif_addr, ADDR_W'(22'h10 + i));
      chk("lone_w0", r0_waitrequest, 1'b0);
      chk("lone_w1", r1_waitrequest, 1'b1);
      tick;
    end
    r0_read = 0;
    #1;
    chk("lone_no5th", ddr_emif_read, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) ret(1'b0, DATA_W'(32'hA000 + i));

    // Fairness: both read continuously, r1 every 5th accept
    r0_read = 1; r0_addr = 22'h100; r0_burst_count = 1;
    r1_read = 1; r1_addr = 22'h200; r1_burst_count = 1;
    tick;
    for (int k = 0; k < 8; k++) begin
      chk("fair_w0", r0_waitrequest, (k == 4));
      chk("fair_w1", r1_waitrequest, (k != 4));
      chk("fair_addr", ddr_emif_addr, (k == 4) ? 22'h200 : 22'h100);
      tick;
    end
    // 8 tags outstanding: the 9th read waits until a pop
    chk("full_w0", r0_waitrequest, 1'b1);
    chk("full_read", ddr_emif_read, 1'b1);
    tick;
    chk("full_w0_held", r0_waitrequest, 1'b1);
    ddr_emif_rddata_valid = 1; ddr_emif_read_data = DATA_W'(32'hB000);
    #1;
    chk("full_pop_v0", r0_rddata_valid, 1'b1);
    chk("full_pop_w0", r0_waitrequest, 1'b1);
    tick;
    ddr_emif_rddata_valid = 0;
    #1;
    chk("after_pop_w0", r0_waitrequest, 1'b0);
    tick;
    r0_read = 0; r1_read = 0;
    tick;
    for (int i = 0; i < 8; i++) ret(fair_own[i], DATA_W'(32'hB100 + i));

    // Atomic write burst of 8, r0 requests from beat 2
    r1_write = 1; r1_addr = 22'h300; r1_burst_count = 8; r1_byte_enable = '1;
    tick;
    for (int b = 0; b < 8; b++) begin
      if (b == 1) begin
        r0_read = 1; r0_addr = 22'h40; r0_burst_count = 1;
        r1_addr = 22'h3FF; r1_burst_count = 3;
      end
      r1_write_data = DATA_W'(b + 1);
      #1;
      chk("wb_write", ddr_emif_write, 1'b1);
      chk("wb_addr", ddr_emif_addr, 22'h300);
      chk("wb_bc", ddr_emif_burst_count, 5'd8);
      chk("wb_data", ddr_emif_write_data, DATA_W'(b + 1));
      chk("wb_w0", r0_waitrequest, 1'b1);
      chk("wb_w1", r1_waitrequest, 1'b0);
      tick;
    end
    r1_write = 0;
    #1;
    chk("wb_r0_granted", r0_waitrequest, 1'b0);
    chk("wb_r0_read", ddr_emif_read, 1'b1);
    chk("wb_r0_addr", ddr_emif_addr, 22'h40);
    chk("wb_done_write", ddr_emif_write, 1'b0);
    tick;
    r0_read = 0;
    tick;
    ret(1'b0, DATA_W'(32'hC000));

    // Tag routing: r0 burst 2, r1 burst 3, r0 burst 1
    rd_cmd(1'b0, 22'h50, 5'd2);
    rd_cmd(1'b1, 22'h60, 5'd3);
    rd_cmd(1'b0, 22'h70, 5'd1);
    for (int i = 0; i < 6; i++) ret(route_own[i], DATA_W'(32'hD000 + i));

    // Backpressure: ready low for 5 cycles holds the grant
    ddr_emif_ready = 0;
    r1_read = 1; r1_addr = 22'h80; r1_burst_count = 1;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_w1", r1_waitrequest, 1'b1);
      chk("bp_w0", r0_waitrequest, 1'b1);
      chk("bp_read", ddr_emif_read, 1'b1);
      chk("bp_addr", ddr_emif_addr, 22'h80);
      tick;
    end
    ddr_emif_ready = 1;
    #1;
    chk("bp_release_w1", r1_waitrequest, 1'b0);
    tick;
    r1_read = 0;
    tick;
    ret(1'b1, DATA_W'(32'hE000));

    // burst_count 0 counts as one beat
    rd_cmd(1'b1, 22'h90, 5'd0);
    ret(1'b1, DATA_W'(32'hE100));
    chk("err_before_orphan", err_orphan, 1'b0);

    // Spurious return with no tags
    ddr_emif_rddata_valid = 1; ddr_emif_read_data = DATA_W'(32'hF000);
    #1;
    chk("orphan_v0", r0_rddata_valid, 1'b0);
    chk("orphan_v1", r1_rddata_valid, 1'b0);
    tick;
    ddr_emif_rddata_valid = 0;
    chk("orphan_err", err_orphan, 1'b1);

    // Async reset with 3 tags outstanding and a grant active
    rd_cmd(1'b0, 22'hA0, 5'd1);
    rd_cmd(1'b0, 22'hA1, 5'd1);
    rd_cmd(1'b0, 22'hA2, 5'd1);
    r0_read = 1; r0_addr = 22'hB0; r0_burst_count = 1;
    tick;
    chk("pre_rst_read", ddr_emif_read, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_read", ddr_emif_read, 1'b0);
    chk("arst_w0", r0_waitrequest, 1'b1);
    chk("arst_w1", r1_waitrequest, 1'b1);
    chk("arst_err", err_orphan, 1'b0);
    r0_read = 0;
    #1;
    rst_n = 1;
    tick;
    ddr_emif_rddata_valid = 1; ddr_emif_read_data = DATA_W'(32'hF100);
    #1;
    chk("post_rst_v0", r0_rddata_valid, 1'b0);
    tick;
    ddr_emif_rddata_valid = 0;
    chk("post_rst_err", err_orphan, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
